sr_40_rx: RTL and testbench

- Serial-to-parallel receive stage directly downstream of the 40 MHz parallel-to-serial shifter.
- Consumes the LSB-first 1-bit stream and reassembles DATA_W-bit words.
- Presents each word on a valid/ready output with overrun and sync-error reporting.
- Sits between the serial link and the word-level consumer logic in the 40 MHz domain.

---
 rtl/sr_40_pkg.sv | 19 +
 rtl/sr_40_rx.sv | 169 ++++++++++++++++
 tb/tb_sr_40_rx.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_40_pkg.sv
// sr_40_pkg: shared types and constants for the 40 MHz serial receive stage.
//   rx_state_e  - receive FSM states (IDLE, SHIFT)
//   DATA_W_DEF  - default assembled word width
//   cnt_w_f()   - bit-counter width for a given word width
package sr_40_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } rx_state_e;

   localparam int DATA_W_DEF = 8;

   // Counter must reach DATA_W when a trailing parity bit is present.
   function automatic int cnt_w_f(input int data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/sr_40_rx.sv
// sr_40_rx: serial-to-parallel receive stage downstream of the 40 MHz shifter.
// Reassembles DATA_W-bit words from a 1-bit stream and presents them on a
// valid/ready output with sticky overrun and a one-cycle sync-error pulse.
//
// Build option: SR40_PAR_CHK_EN adds a trailing even-parity bit to every frame
// and reports the check result on parity_err (otherwise parity_err is 0).
//
// Ports:
//   clock_40    in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   serial_in   in   serial data bit
//   bit_valid   in   serial_in is sampled this cycle
//   frame_start in   sampled bit is bit 0 of a frame
//   data_out    out  assembled word
//   data_valid  out  data_out holds an unconsumed word
//   data_ready  in   consumer accepts data_out
//   overrun     out  sticky: a completed word was dropped
//   sync_err    out  pulse: a partial word was aborted by frame_start
//   clr_flags   in   synchronous clear of overrun
//   parity_err  out  parity result for the word in data_out
//
// state | meaning
// IDLE  | waiting for a valid bit qualified by frame_start
// SHIFT | collecting bits 1..FRAME_LEN-1 of the current frame
module sr_40_rx
   import sr_40_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic              clock_40,
   input  logic              reset,
   input  logic              serial_in,
   input  logic              bit_valid,
   input  logic              frame_start,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              overrun,
   output logic              sync_err,
   input  logic              clr_flags,
   output logic              parity_err
);

   localparam int CNT_W = cnt_w_f(DATA_W);
`ifdef SR40_PAR_CHK_EN
   localparam int FRAME_LEN = DATA_W + 1;
`else
   localparam int FRAME_LEN = DATA_W;
`endif
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);
   localparam int               FIRST_POS = LSB_FIRST ? 0 : DATA_W - 1;

   rx_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              overrun_q, overrun_d;
   logic              sync_err_q, sync_err_d;
   logic              par_q, par_d;

   logic [DATA_W-1:0] ins_word;
   logic [DATA_W-1:0] fresh_word;
   logic              word_done;
   logic              done_par;

   // Current bit dropped into its slot. The parity bit (cnt = DATA_W) matches
   // no slot, so ins_word is then just the collected data bits.
   always_comb begin
      ins_word = shift_q;
      for (int i = 0; i < DATA_W; i++) begin
         if (cnt_q == CNT_W'(LSB_FIRST ? i : DATA_W - 1 - i)) begin
            ins_word[i] = serial_in;
         end
      end
   end

   always_comb begin
      fresh_word            = '0;
      fresh_word[FIRST_POS] = serial_in;
   end

`ifdef SR40_PAR_CHK_EN
   assign done_par = (^shift_q) ^ serial_in;
`else
   assign done_par = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      sync_err_d = 1'b0;
      word_done  = 1'b0;
      if (bit_valid) begin
         if (frame_start) begin
            // Frames are at least 2 bits, so a start bit is never the last one.
            sync_err_d = (state_q == SHIFT);
            state_d    = SHIFT;
            cnt_d      = CNT_W'(1);
            shift_d    = fresh_word;
         end else if (state_q == SHIFT) begin
            if (cnt_q == CNT_LAST) begin
               word_done = 1'b1;
               state_d   = IDLE;
               cnt_d     = '0;
               shift_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               shift_d = ins_word;
            end
         end
      end
   end

   // Output register: a completing word loads unless the held word is
   // still unaccepted, in which case it is dropped and overrun is flagged.
   always_comb begin
      data_d    = data_q;
      par_d     = par_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (valid_q && data_ready) begin
         valid_d = 1'b0;
      end
      if (clr_flags) begin
         overrun_d = 1'b0;
      end
      if (word_done) begin
         if (!valid_q || data_ready) begin
            data_d  = ins_word;
            par_d   = done_par;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock_40 or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
         sync_err_q <= 1'b0;
         par_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
         sync_err_q <= sync_err_d;
         par_q      <= par_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign overrun    = overrun_q;
   assign sync_err   = sync_err_q;
   assign parity_err = par_q;

endmodule

// File: tb/tb_sr_40_rx.sv
// tb_sr_40_rx: self-checking bench for sr_40_rx (DATA_W=8, LSB_FIRST=1).
// Honours SR40_PAR_CHK_EN: frames then carry a trailing parity bit.
`timescale 1ns/100ps
module tb_sr_40_rx;

   localparam int DW = 8;
`ifdef SR40_PAR_CHK_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int FL = DW + (PAR ? 1 : 0);

   logic          clock_40 = 1'b0;
   logic          reset = 1'b0;
   logic          serial_in = 1'b0;
   logic          bit_valid = 1'b0;
   logic          frame_start = 1'b0;
   logic          data_ready = 1'b0;
   logic          clr_flags = 1'b0;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          overrun;
   logic          sync_err;
   logic          parity_err;

   int n_cmp = 0;
   int n_err = 0;
   int sync_seen = 0;

   sr_40_rx #(.DATA_W(DW), .LSB_FIRST(1'b1)) dut (
      .clock_40    (clock_40),
      .reset       (reset),
      .serial_in   (serial_in),
      .bit_valid   (bit_valid),
      .frame_start (frame_start),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .overrun     (overrun),
      .sync_err    (sync_err),
      .clr_flags   (clr_flags),
      .parity_err  (parity_err)
   );

   always #12.5 clock_40 = ~clock_40;

   always @(negedge clock_40) if (sync_err === 1'b1) sync_seen++;

   // Reference: bit k of a frame is word bit k (LSB first), then the parity bit.
   function automatic logic frame_bit(input logic [DW-1:0] w, input logic p, input int k);
      return (k < DW) ? w[k] : p;
   endfunction

   // Reference: parity_err is the XOR of data and parity bit, else always 0.
   function automatic logic exp_par(input logic [DW-1:0] w, input logic p);
      return PAR ? ((^w) ^ p) : 1'b0;
   endfunction

   task automatic tick();
      @(posedge clock_40);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic fs, input int gap);
      serial_in   = b;
      bit_valid   = 1'b1;
      frame_start = fs;
      tick();
      bit_valid   = 1'b0;
      frame_start = 1'b0;
      serial_in   = 1'($urandom_range(0, 1));
      repeat (gap) tick();
   endtask

   task automatic send_frame(input logic [DW-1:0] w, input logic p, input int gap,
                             input bit ready_on_last);
      for (int k = 0; k < FL; k++) begin
         if (k == FL - 1 && ready_on_last) data_ready = 1'b1;
         send_bit(frame_bit(w, p, k), k == 0, (k == FL - 1) ? 0 : gap);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if ({data_out, data_valid, overrun, sync_err, parity_err} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got out=%h v=%b ov=%b se=%b pe=%b, want all 0",
                  data_out, data_valid, overrun, sync_err, parity_err);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_single();
      logic [DW-1:0] w = 8'hA5;
      data_ready = 1'b1;
      for (int k = 0; k < FL; k++) begin
         send_bit(frame_bit(w, ^w, k), k == 0, 0);
         if (k < FL - 1) begin
            n_cmp++;
            if (data_valid !== 1'b0) begin
               n_err++;
               $display("FAIL single_early_valid bit %0d: got %b, want 0", k, data_valid);
            end
         end
      end
      n_cmp++;
      if (data_out !== w || data_valid !== 1'b1 || parity_err !== 1'b0) begin
         n_err++;
         $display("FAIL single_word: got out=%h v=%b pe=%b, want out=%h v=1 pe=0",
                  data_out, data_valid, parity_err, w);
      end
      tick();
      n_cmp++;
      if (data_valid !== 1'b0) begin
         n_err++;
         $display("FAIL single_valid_drop: got %b, want 0", data_valid);
      end
   endtask

   task automatic test_gapped();
      logic [DW-1:0] w = 8'h3C;
      int bad = 0;
      data_ready = 1'b1;
      for (int k = 0; k < FL; k++) begin
         send_bit(frame_bit(w, ^w, k), k == 0, (k == FL - 1) ? 0 : 3);
         if (k < FL - 1 && (data_valid !== 1'b0 || sync_err !== 1'b0)) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL gapped_quiet: got %0d cycles with valid/sync_err, want 0", bad);
      end
      n_cmp++;
      if (data_out !== w || data_valid !== 1'b1) begin
         n_err++;
         $display("FAIL gapped_word: got out=%h v=%b, want out=%h v=1", data_out, data_valid, w);
      end
      tick();
   endtask

   task automatic test_overrun();
      data_ready = 1'b0;
      send_frame(8'h11, ^8'h11, 1, 1'b0);
      send_frame(8'h22, ^8'h22, 0, 1'b0);
      n_cmp++;
      if (data_out !== 8'h11 || data_valid !== 1'b1 || overrun !== 1'b1) begin
         n_err++;
         $display("FAIL overrun_drop: got out=%h v=%b ov=%b, want out=11 v=1 ov=1",
                  data_out, data_valid, overrun);
      end
      tick();
      n_cmp++;
      if (overrun !== 1'b1) begin
         n_err++;
         $display("FAIL overrun_sticky: got %b, want 1", overrun);
      end
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      n_cmp++;
      if (overrun !== 1'b0 || data_out !== 8'h11 || data_valid !== 1'b1) begin
         n_err++;
         $display("FAIL overrun_clear: got ov=%b out=%h v=%b, want ov=0 out=11 v=1",
                  overrun, data_out, data_valid);
      end
   endtask

   task automatic test_same_edge();
      send_frame(8'h22, ^8'h22, 0, 1'b1);
      n_cmp++;
      if (data_out !== 8'h22 || data_valid !== 1'b1 || overrun !== 1'b0) begin
         n_err++;
         $display("FAIL same_edge_load: got out=%h v=%b ov=%b, want out=22 v=1 ov=0",
                  data_out, data_valid, overrun);
      end
      tick();
      n_cmp++;
      if (data_valid !== 1'b0) begin
         n_err++;
         $display("FAIL same_edge_accept: got v=%b, want 0", data_valid);
      end
   endtask

   task automatic test_resync();
      logic [DW-1:0] w = 8'h5A;
      data_ready = 1'b1;
      send_bit(1'b1, 1'b1, 0);
      send_bit(1'b0, 1'b0, 0);
      send_bit(1'b1, 1'b0, 0);
      n_cmp++;
      if (sync_err !== 1'b0) begin
         n_err++;
         $display("FAIL resync_quiet: got sync_err=%b, want 0", sync_err);
      end
      for (int k = 0; k < FL; k++) begin
         send_bit(frame_bit(w, ^w, k), k == 0, 0);
         if (k <= 1) begin
            n_cmp++;
            if (sync_err !== (k == 0)) begin
               n_err++;
               $display("FAIL resync_pulse bit %0d: got %b, want %b", k, sync_err, k == 0);
            end
         end
      end
      n_cmp++;
      if (data_out !== w || data_valid !== 1'b1) begin
         n_err++;
         $display("FAIL resync_word: got out=%h v=%b, want out=%h v=1", data_out, data_valid, w);
      end
      tick();
   endtask

   task automatic test_async_reset();
      logic [DW-1:0] w = 8'hFF;
      data_ready = 1'b0;
      send_frame(8'h77, ~(^8'h77), 0, 1'b0);
      send_frame(8'h33, ^8'h33, 0, 1'b0);
      for (int k = 0; k < 4; k++) send_bit(frame_bit(8'hC3, 1'b0, k), k == 0, 0);
      #3 reset = 1'b0;
      #1;
      n_cmp++;
      if ({data_out, data_valid, overrun, sync_err, parity_err} !== '0) begin
         n_err++;
         $display("FAIL async_reset: got out=%h v=%b ov=%b se=%b pe=%b, want all 0",
                  data_out, data_valid, overrun, sync_err, parity_err);
      end
      #5 reset = 1'b1;
      tick();
      data_ready = 1'b1;
      send_frame(w, 1'b1, 0, 1'b0);
      n_cmp++;
      if (data_out !== w || data_valid !== 1'b1 || parity_err !== exp_par(w, 1'b1)) begin
         n_err++;
         $display("FAIL after_reset_word: got out=%h v=%b pe=%b, want out=%h v=1 pe=%b",
                  data_out, data_valid, parity_err, w, exp_par(w, 1'b1));
      end
      tick();
   endtask

   task automatic test_random();
      int snap = sync_seen;
      int exp_sync = 0;
      int bad = 0;
      data_ready = 1'b1;
      for (int it = 0; it < 40; it++) begin
         logic [DW-1:0] w = DW'($urandom);
         logic p = 1'($urandom_range(0, 1));
         int gap = $urandom_range(0, 2);
         if ($urandom_range(0, 4) == 0) begin
            int n = $urandom_range(1, FL - 1);
            for (int k = 0; k < n; k++) send_bit(1'($urandom_range(0, 1)), k == 0, gap);
            exp_sync++;
         end
         send_frame(w, p, gap, 1'b0);
         n_cmp++;
         if (data_out !== w || data_valid !== 1'b1 || parity_err !== exp_par(w, p)) begin
            n_err++;
            bad++;
            $display("FAIL random_word %0d: got out=%h v=%b pe=%b, want out=%h v=1 pe=%b",
                     it, data_out, data_valid, parity_err, w, exp_par(w, p));
         end
      end
      repeat (2) tick();
      n_cmp++;
      if (sync_seen - snap != exp_sync) begin
         n_err++;
         $display("FAIL random_sync_count: got %0d pulses, want %0d", sync_seen - snap, exp_sync);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_gapped();
      test_overrun();
      test_same_edge();
      test_resync();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
